// File: rtl/wt_sched_pkg.sv
// wt_sched_pkg: shared states, RAM geometry and sample conversion for wt_voice_sched.
// WT_GAIN_EN adds the MACC state used by the registered gain product.
package wt_sched_pkg;
  typedef enum logic [2:0] {
    IDLE, READ, CAPT, DONE
`ifdef WT_GAIN_EN
    , MACC
`endif
  } state_e;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int OFFSET_BIN_MSB = DATA_W - 1;
  function automatic logic signed [DATA_W-1:0] offset_to_signed(input logic [DATA_W-1:0] d);
    return {~d[OFFSET_BIN_MSB], d[OFFSET_BIN_MSB-1:0]};
  endfunction
endpackage

// File: rtl/wt_phase_acc.sv
// wt_phase_acc: one voice phase accumulator; steps by inc when enabled, clears when disabled.
module wt_phase_acc #(
  parameter int PHASE_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  input  logic               en,
  input  logic [PHASE_W-1:0] inc,
  output logic [PHASE_W-1:0] phase
);
  logic [PHASE_W-1:0] phase_q, phase_d;
  always_comb phase_d = step ? (en ? phase_q + inc : '0) : phase_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) phase_q <= '0;
    else phase_q <= phase_d;
  assign phase = phase_q;
endmodule

// File: rtl/wt_voice_sched.sv
// wt_voice_sched: time-multiplexed wavetable voice scheduler and mixer over a 1-cycle-read RAM.
// Define WT_GAIN_EN for per-voice 8-bit gain (adds one registered cycle per voice).
module wt_voice_sched
  import wt_sched_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_tick,
  input  logic [NUM_VOICES-1:0]         voice_en,
  input  logic [NUM_VOICES*PHASE_W-1:0] phase_inc,
`ifdef WT_GAIN_EN
  input  logic [NUM_VOICES*8-1:0]       voice_gain,
`endif
  output logic [ADDR_W-1:0]             ram_addr,
  output logic                          ram_ce,
  output logic                          ram_re,
  output logic                          ram_we,
  input  logic [DATA_W-1:0]             ram_rdata,
  output logic [DATA_W-1:0]             sample_out,
  output logic                          sample_valid,
  output logic                          busy,
  output logic                          overrun
);
  localparam int LG = $clog2(NUM_VOICES);
  localparam int VW = LG > 0 ? LG : 1;
  localparam int AW = DATA_W + LG;
  state_e state_q, state_d;
  logic [VW-1:0] v_q, v_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic en_q, en_d, ovr_q, ovr_d, last;
  logic [ADDR_W-1:0] addr_q, addr_d, cur_addr;
  logic [DATA_W-1:0] out_q, out_d;
  logic signed [DATA_W-1:0] s, term;
  logic [PHASE_W-1:0] phase [NUM_VOICES];
  genvar i;
  for (i = 0; i < NUM_VOICES; i++) begin : g_voice
    wt_phase_acc #(.PHASE_W(PHASE_W)) u_acc (
      .clk  (clk),
      .rst  (rst),
      .step (state_q == READ && v_q == VW'(i)),
      .en   (voice_en[i]),
      .inc  (phase_inc[i*PHASE_W +: PHASE_W]),
      .phase(phase[i])
    );
  end
  assign s = offset_to_signed(ram_rdata);
  assign last = v_q == VW'(NUM_VOICES - 1);
  assign cur_addr = phase[v_q][PHASE_W-1 -: ADDR_W];
`ifdef WT_GAIN_EN
  localparam state_e FOLD = MACC;
  logic signed [DATA_W-1:0] prod_q, prod_d;
  logic signed [DATA_W+8:0] p;
  assign p = (DATA_W+9)'(s) * (DATA_W+9)'($signed({1'b0, voice_gain[v_q*8 +: 8]}));
  always_comb prod_d = state_q == CAPT ? (en_q ? p[DATA_W+7:8] : '0) : prod_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) prod_q <= '0;
    else prod_q <= prod_d;
  assign term = prod_q;
`else
  localparam state_e FOLD = CAPT;
  assign term = en_q ? s : '0;
`endif
  always_comb begin
    state_d = state_q;
    v_d = v_q;
    acc_d = acc_q;
    en_d = en_q;
    addr_d = addr_q;
    out_d = out_q;
    ovr_d = sample_tick && state_q != IDLE;
    if (state_q == IDLE && sample_tick) begin
      state_d = READ;
      v_d = '0;
      acc_d = '0;
    end
    if (state_q == READ) begin
      state_d = CAPT;
      en_d = voice_en[v_q];
      addr_d = cur_addr;
    end
`ifdef WT_GAIN_EN
    if (state_q == CAPT) state_d = MACC;
`endif
    if (state_q == FOLD) begin
      acc_d = acc_q + AW'(term);
      state_d = last ? DONE : READ;
      v_d = last ? v_q : v_q + 1'b1;
      out_d = last ? DATA_W'(acc_d >>> LG) : out_q;
    end
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      v_q <= '0;
      acc_q <= '0;
      en_q <= 1'b0;
      ovr_q <= 1'b0;
      addr_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      v_q <= v_d;
      acc_q <= acc_d;
      en_q <= en_d;
      ovr_q <= ovr_d;
      addr_q <= addr_d;
      out_q <= out_d;
    end
  assign ram_addr = state_q == READ ? cur_addr : addr_q;
  assign ram_ce = state_q == READ;
  assign ram_re = state_q == READ;
  assign ram_we = 1'b0;
  assign sample_out = out_q;
  assign sample_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_wt_voice_sched.sv
// tb_wt_voice_sched: randomized and directed checks of wt_voice_sched against a sweep-level mixing model.
module tb_wt_voice_sched;
  localparam int NV = 4;
`ifdef WT_GAIN_EN
  localparam int LAT = 3*NV + 1;
  localparam bit GAIN = 1'b1;
`else
  localparam int LAT = 2*NV + 1;
  localparam bit GAIN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, sample_tick = 1'b0;
  logic [NV-1:0] voice_en = '0;
  logic [NV*24-1:0] phase_inc = '0;
  logic [NV*8-1:0] voice_gain = '1;
  logic [8:0] ram_addr;
  logic ram_ce, ram_re, ram_we, sample_valid, busy, overrun;
  logic [15:0] ram_rdata = '0, sample_out;
  logic [15:0] mem [512];
  int unsigned m_phase [NV];
  int exp_addr [NV];
  int addrq [$];
  int checks = 0, fails = 0;

  wt_voice_sched #(.NUM_VOICES(NV), .PHASE_W(24)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .voice_en(voice_en), .phase_inc(phase_inc),
`ifdef WT_GAIN_EN
    .voice_gain(voice_gain),
`endif
    .ram_addr(ram_addr), .ram_ce(ram_ce), .ram_re(ram_re), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (ram_ce && ram_re) ram_rdata <= mem[ram_addr];
  always @(negedge clk) if (ram_ce) addrq.push_back(int'(ram_addr));

  task automatic model_sweep(output logic [15:0] exp);
    int sum, a, sv, g;
    sum = 0;
    for (int v = 0; v < NV; v++) begin
      a = int'(m_phase[v] >> 15);
      sv = int'(mem[a]) - 32768;
      g = int'(voice_gain[v*8 +: 8]);
      exp_addr[v] = a;
      if (voice_en[v]) begin
        sum += GAIN ? ((sv * g) >>> 8) : sv;
        m_phase[v] = (m_phase[v] + 32'(phase_inc[v*24 +: 24])) & 32'hFF_FFFF;
      end else m_phase[v] = 0;
    end
    exp = 16'(sum >>> 2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sample_tick = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int v = 0; v < NV; v++) m_phase[v] = 0;
  endtask

  task automatic tick_sweep(output int lat, output logic [15:0] so);
    lat = -1;
    so = 'x;
    addrq.delete();
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      if (c > 1) @(negedge clk);
      if (sample_valid) begin
        lat = c;
        so = sample_out;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, sample_valid, overrun, ram_ce, ram_re, ram_we} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 000000", {busy, sample_valid, overrun, ram_ce, ram_re, ram_we});
    end
    do_reset();
    #1;
    checks++;
    if (sample_out !== 16'h0) begin fails++; $display("FAIL reset_out: got %h want 0000", sample_out); end
    checks++;
    if (ram_addr !== 9'h0) begin fails++; $display("FAIL reset_addr: got %h want 000", ram_addr); end
  endtask

  task automatic test_ramp();
    int lat;
    logic [15:0] so, exp;
    for (int a = 0; a < 512; a++) mem[a] = 16'h8000 + 16'(a << 4);
    voice_en = 4'b0001;
    phase_inc = '0;
    phase_inc[23:0] = 24'h008000;
    do_reset();
    for (int t = 0; t < 5; t++) begin
      model_sweep(exp);
      tick_sweep(lat, so);
      checks++;
      if (lat !== LAT) begin fails++; $display("FAIL ramp_lat: got %0d want %0d", lat, LAT); end
      checks++;
      if (so !== exp) begin fails++; $display("FAIL ramp_out t=%0d: got %h want %h", t, so, exp); end
`ifndef WT_GAIN_EN
      checks++;
      if (so !== 16'(t * 4)) begin fails++; $display("FAIL ramp_const t=%0d: got %h want %h", t, so, 16'(t*4)); end
`endif
      checks++;
      if (addrq.size() != NV || addrq[0] != t) begin
        fails++;
        $display("FAIL ramp_addr t=%0d: got %0d reads, first %0d want %0d reads, first %0d", t, addrq.size(), addrq.size() ? addrq[0] : -1, NV, t);
      end
    end
  endtask

  task automatic test_wrap();
    int lat;
    logic [15:0] so, exp;
    phase_inc[23:0] = 24'hFF8000;
    do_reset();
    model_sweep(exp);
    tick_sweep(lat, so);
    model_sweep(exp);
    tick_sweep(lat, so);
    checks++;
    if (so !== exp) begin fails++; $display("FAIL wrap_out: got %h want %h", so, exp); end
`ifndef WT_GAIN_EN
    checks++;
    if (so !== 16'h07FC) begin fails++; $display("FAIL wrap_const: got %h want 07fc", so); end
`endif
    checks++;
    if (addrq.size() == 0 || addrq[0] != 'h1FF) begin fails++; $display("FAIL wrap_addr: got %0d want 511", addrq.size() ? addrq[0] : -1); end
  endtask

  task automatic test_all_en();
    int lat;
    logic [15:0] so, exp;
    logic [15:0] vals [3];
    logic [15:0] want [3];
    vals = '{16'h8000, 16'hFFFF, 16'h0000};
    want = '{16'h0000, 16'h7FFF, 16'h8000};
    voice_en = 4'b1111;
    phase_inc = '0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      mem[0] = vals[k];
      model_sweep(exp);
      tick_sweep(lat, so);
      checks++;
      if (so !== exp) begin fails++; $display("FAIL all_en_out k=%0d: got %h want %h", k, so, exp); end
`ifndef WT_GAIN_EN
      checks++;
      if (so !== want[k]) begin fails++; $display("FAIL all_en_const k=%0d: got %h want %h", k, so, want[k]); end
`endif
    end
  endtask

  task automatic test_timing(input bit with_ovr);
    int pulses;
    logic [2:0] got, want;
    pulses = 0;
    do_reset();
    @(negedge clk);
    sample_tick = 1'b1;
    for (int c = 1; c <= LAT + 4; c++) begin
      @(negedge clk);
      sample_tick = with_ovr && c == 4;
      got = {busy, sample_valid, overrun};
      want = {c <= LAT, c == LAT, with_ovr && c == 5};
      pulses += sample_valid;
      checks++;
      if (got !== want) begin fails++; $display("FAIL timing ovr=%0d c=%0d: got %b want %b", with_ovr, c, got, want); end
    end
    checks++;
    if (pulses != 1) begin fails++; $display("FAIL timing_pulses ovr=%0d: got %0d want 1", with_ovr, pulses); end
  endtask

  task automatic test_reset_mid();
    int lat, pulses;
    logic [15:0] so, exp;
    for (int a = 0; a < 512; a++) mem[a] = 16'h8000 + 16'(a << 4);
    voice_en = 4'b0001;
    phase_inc = '0;
    phase_inc[23:0] = 24'h008000;
    do_reset();
    repeat (2) begin
      model_sweep(exp);
      tick_sweep(lat, so);
    end
    @(negedge clk);
    sample_tick = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      sample_tick = 1'b0;
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, sample_valid} !== 2'b00 || sample_out !== 16'h0) begin
      fails++;
      $display("FAIL reset_mid: got busy=%b valid=%b out=%h want 0 0 0000", busy, sample_valid, sample_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int v = 0; v < NV; v++) m_phase[v] = 0;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      pulses += sample_valid + busy;
    end
    checks++;
    if (pulses != 0) begin fails++; $display("FAIL reset_mid_quiet: got %0d active cycles want 0", pulses); end
    for (int t = 0; t < 2; t++) begin
      model_sweep(exp);
      tick_sweep(lat, so);
      checks++;
      if (so !== exp || lat !== LAT || addrq.size() == 0 || addrq[0] != t) begin
        fails++;
        $display("FAIL reset_mid_resume t=%0d: got out=%h lat=%0d want out=%h lat=%0d addr=%0d", t, so, lat, exp, LAT, t);
      end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [15:0] so, exp;
    do_reset();
    for (int t = 0; t < 25; t++) begin
      for (int a = 0; a < 512; a++) mem[a] = 16'($urandom);
      voice_en = NV'($urandom);
      for (int v = 0; v < NV; v++) begin
        phase_inc[v*24 +: 24] = ($urandom_range(0, 1) != 0) ? 24'($urandom) : 24'($urandom_range(0, 3) << 15);
        voice_gain[v*8 +: 8] = 8'($urandom);
      end
      model_sweep(exp);
      tick_sweep(lat, so);
      checks++;
      if (so !== exp || lat !== LAT) begin
        fails++;
        $display("FAIL random t=%0d: got out=%h lat=%0d want out=%h lat=%0d", t, so, lat, exp, LAT);
      end
      for (int v = 0; v < NV; v++) begin
        checks++;
        if (addrq.size() != NV || addrq[v] != exp_addr[v]) begin
          fails++;
          $display("FAIL random_addr t=%0d v=%0d: got %0d want %0d", t, v, addrq.size() == NV ? addrq[v] : -1, exp_addr[v]);
        end
      end
    end
    voice_gain = '1;
  endtask

`ifdef WT_GAIN_EN
  task automatic test_gain();
    int lat;
    logic [15:0] so;
    mem[0] = 16'hC000;
    voice_en = 4'b0001;
    phase_inc = '0;
    voice_gain = '0;
    voice_gain[7:0] = 8'h80;
    do_reset();
    tick_sweep(lat, so);
    checks++;
    if (so !== 16'h0800 || lat !== 13) begin fails++; $display("FAIL gain: got out=%h lat=%0d want 0800 13", so, lat); end
    voice_gain = '1;
  endtask
`endif

  initial begin
    test_reset();
    test_ramp();
    test_wrap();
    test_all_en();
    test_timing(1'b0);
    test_timing(1'b1);
    test_reset_mid();
    test_random();
`ifdef WT_GAIN_EN
    test_gain();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
